// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
// Module   : cpu_pkg
// Brief    : Shared encodings for the execute unit: FSM states, opcodes and
//            the multiplier iteration count.
// Revision : 1.0 - initial release
// ============================================================================
package cpu_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_READ = 3'd1,
        ST_EXEC = 3'd2,
        ST_MUL  = 3'd3,
        ST_WB   = 3'd4
    } state_t;

    typedef enum logic [2:0] {
        OP_ADD = 3'b000,
        OP_SUB = 3'b001,
        OP_AND = 3'b010,
        OP_OR  = 3'b011,
        OP_XOR = 3'b100,
        OP_SLT = 3'b101,
        OP_MUL = 3'b110,
        OP_MOV = 3'b111
    } opcode_t;

    localparam int c_mul_iter  = 16;
    localparam int c_mul_cnt_w = $clog2(c_mul_iter);

endpackage
`default_nettype wire

// File: rtl/alu_comb.sv
`default_nettype none
// ============================================================================
// Module   : alu_comb
// Brief    : Single-cycle combinational ALU (ADD..MOV) with carry/zero status.
// Revision : 1.0 - initial release
// ============================================================================
module alu_comb
    import cpu_pkg::*;
#(
    parameter int DATA_W = 16
) (
    input  opcode_t           i_opcode,
    input  logic [DATA_W-1:0] i_a,
    input  logic [DATA_W-1:0] i_b,
    output logic [DATA_W-1:0] o_result,
    output logic              o_carry,
    output logic              o_zero
);

    logic [DATA_W:0] w_sum;
    logic            w_lt;

    assign w_sum = {1'b0, i_a} + {1'b0, i_b};
    assign w_lt  = (i_a < i_b);

    always_comb begin
        o_result = '0;
        o_carry  = 1'b0;
        case (i_opcode)
            OP_ADD: begin
                o_result = w_sum[DATA_W-1:0];
                o_carry  = w_sum[DATA_W];
            end
            OP_SUB: begin
                o_result = i_a - i_b;
                o_carry  = w_lt;    // borrow
            end
            OP_AND:  o_result = i_a & i_b;
            OP_OR:   o_result = i_a | i_b;
            OP_XOR:  o_result = i_a ^ i_b;
            OP_SLT:  o_result = {{(DATA_W-1){1'b0}}, w_lt};
            OP_MOV:  o_result = i_a;
            default: o_result = '0;     // MUL is handled iteratively upstream
        endcase
    end

    assign o_zero = (o_result == '0);

endmodule
`default_nettype wire

// File: rtl/execute_unit.sv
`default_nettype none
// ============================================================================
// Module   : execute_unit
// Brief    : Multi-cycle execute stage: register read, ALU or shift-add
//            multiply, single-cycle register write-back with status flags.
// Revision : 1.0 - initial release
// ============================================================================
module execute_unit
    import cpu_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [2:0]        opcode,
    input  logic [ADDR_W-1:0] rs1,
    input  logic [ADDR_W-1:0] rs2,
    input  logic [ADDR_W-1:0] rd,
    output logic [ADDR_W-1:0] address_a,
    output logic [ADDR_W-1:0] address_b,
    input  logic [DATA_W-1:0] data_a,
    input  logic [DATA_W-1:0] data_b,
    output logic              write_enable,
    output logic [ADDR_W-1:0] address_w,
    output logic [DATA_W-1:0] data_in_w,
    output logic              busy,
    output logic              done,
    output logic              flag_zero,
    output logic              flag_carry
);

    state_t                 r_state;
    state_t                 w_state_next;
    opcode_t                r_opcode;
    logic [ADDR_W-1:0]      r_rs1;
    logic [ADDR_W-1:0]      r_rs2;
    logic [ADDR_W-1:0]      r_rd;
    logic [DATA_W-1:0]      r_op_a;
    logic [DATA_W-1:0]      r_op_b;
    logic [DATA_W-1:0]      r_acc;
    logic [c_mul_cnt_w-1:0] r_cnt;
    logic                   r_carry_pend;
    logic                   r_we;
    logic                   r_done;
    logic [ADDR_W-1:0]      r_address_w;
    logic [DATA_W-1:0]      r_data_in_w;
    logic                   r_flag_zero;
    logic                   r_flag_carry;

    logic [DATA_W-1:0]      w_alu_result;
    logic                   w_alu_carry;
    logic                   w_alu_zero;
    logic [DATA_W-1:0]      w_acc_next;
    logic                   w_mul_last;
    logic                   w_enter_wb;

    alu_comb #(
        .DATA_W (DATA_W)
    ) u_alu (
        .i_opcode (r_opcode),
        .i_a      (r_op_a),
        .i_b      (r_op_b),
        .o_result (w_alu_result),
        .o_carry  (w_alu_carry),
        .o_zero   (w_alu_zero)
    );

    // Multiplicand shifts left and multiplier shifts right each MUL cycle
    assign w_acc_next = r_acc + (r_op_b[0] ? r_op_a : '0);
    assign w_mul_last = (r_cnt == c_mul_cnt_w'(c_mul_iter - 1));

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: if (start) w_state_next = ST_READ;
            ST_READ: w_state_next = ST_EXEC;
            ST_EXEC: w_state_next = (r_opcode == OP_MUL) ? ST_MUL : ST_WB;
            ST_MUL:  if (w_mul_last) w_state_next = ST_WB;
            ST_WB:   w_state_next = ST_IDLE;
            default: w_state_next = ST_IDLE;
        endcase
    end

    assign w_enter_wb = (w_state_next == ST_WB);

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_opcode     <= OP_ADD;
            r_rs1        <= '0;
            r_rs2        <= '0;
            r_rd         <= '0;
            r_op_a       <= '0;
            r_op_b       <= '0;
            r_acc        <= '0;
            r_cnt        <= '0;
            r_carry_pend <= 1'b0;
            r_we         <= 1'b0;
            r_done       <= 1'b0;
            r_address_w  <= '0;
            r_data_in_w  <= '0;
            r_flag_zero  <= 1'b0;
            r_flag_carry <= 1'b0;
        end else begin
            r_we   <= w_enter_wb;
            r_done <= w_enter_wb;
            // Write port registers only move on WB entry so they hold otherwise
            if (w_enter_wb) begin
                r_address_w <= r_rd;
                r_data_in_w <= (r_state == ST_MUL) ? w_acc_next : w_alu_result;
            end
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_opcode <= opcode_t'(opcode);
                        r_rs1    <= rs1;
                        r_rs2    <= rs2;
                        r_rd     <= rd;
                    end
                end
                ST_READ: begin
                    r_op_a <= data_a;
                    r_op_b <= data_b;
                end
                ST_EXEC: begin
                    if (r_opcode == OP_MUL) begin
                        r_acc        <= '0;
                        r_cnt        <= '0;
                        r_carry_pend <= 1'b0;
                    end else begin
                        r_carry_pend <= w_alu_carry;
                    end
                end
                ST_MUL: begin
                    r_acc  <= w_acc_next;
                    r_op_a <= r_op_a << 1;
                    r_op_b <= r_op_b >> 1;
                    r_cnt  <= r_cnt + 1'b1;
                end
                ST_WB: begin
                    r_flag_zero  <= (r_data_in_w == '0);
                    r_flag_carry <= r_carry_pend;
                end
                default: ;
            endcase
        end
    end

    assign address_a    = r_rs1;
    assign address_b    = r_rs2;
    assign write_enable = r_we;
    assign done         = r_done;
    assign address_w    = r_address_w;
    assign data_in_w    = r_data_in_w;
    assign busy         = (r_state != ST_IDLE);
    assign flag_zero    = r_flag_zero;
    assign flag_carry   = r_flag_carry;

    // ALU zero status is recomputed from the written value at WB
    logic w_unused;
    assign w_unused = w_alu_zero;

endmodule
`default_nettype wire

// File: tb/tb_execute_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_execute_unit
// Brief    : Scoreboard bench for execute_unit with a behavioural register bank.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_execute_unit;
    import cpu_pkg::*;

    localparam int DATA_W = 16;
    localparam int ADDR_W = 4;

    logic              clk = 1'b0;
    logic              reset;
    logic              start;
    logic [2:0]        opcode;
    logic [ADDR_W-1:0] rs1, rs2, rd;
    logic [ADDR_W-1:0] address_a, address_b, address_w;
    logic [DATA_W-1:0] data_a, data_b, data_in_w;
    logic              write_enable, busy, done, flag_zero, flag_carry;

    always #5 clk = ~clk;

    execute_unit #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .opcode       (opcode),
        .rs1          (rs1),
        .rs2          (rs2),
        .rd           (rd),
        .address_a    (address_a),
        .address_b    (address_b),
        .data_a       (data_a),
        .data_b       (data_b),
        .write_enable (write_enable),
        .address_w    (address_w),
        .data_in_w    (data_in_w),
        .busy         (busy),
        .done         (done),
        .flag_zero    (flag_zero),
        .flag_carry   (flag_carry)
    );

    logic [DATA_W-1:0] regs [16];
    logic              load_en;
    logic [ADDR_W-1:0] load_addr;
    logic [DATA_W-1:0] load_data;

    assign data_a = regs[address_a];
    assign data_b = regs[address_b];

    always @(posedge clk) begin
        if (write_enable) regs[address_w] <= data_in_w;
        else if (load_en) regs[load_addr] <= load_data;
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
        logic              zero;
        logic              carry;
        int                wb_cyc;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic exp_t model(input logic [2:0] op, input logic [DATA_W-1:0] a,
                                   input logic [DATA_W-1:0] b, input logic [ADDR_W-1:0] d,
                                   input int wb);
        exp_t        e;
        logic [16:0] s;
        logic [31:0] p;
        e.carry = 1'b0;
        e.data  = '0;
        case (op)
            3'd0: begin s = {1'b0, a} + {1'b0, b}; e.data = s[15:0]; e.carry = s[16]; end
            3'd1: begin e.data = a - b; e.carry = (a < b); end
            3'd2: e.data = a & b;
            3'd3: e.data = a | b;
            3'd4: e.data = a ^ b;
            3'd5: e.data = (a < b) ? 16'd1 : 16'd0;
            3'd6: begin p = {16'd0, a} * {16'd0, b}; e.data = p[15:0]; end
            default: e.data = a;
        endcase
        e.zero   = (e.data == 16'd0);
        e.addr   = d;
        e.wb_cyc = wb;
        return e;
    endfunction

    // Scoreboard monitor: write-back contents/timing, then flags one cycle later
    logic flag_pend = 1'b0;
    logic exp_z, exp_c;
    always @(negedge clk) begin
        exp_t e;
        if (flag_pend) begin
            check("flag_zero", {31'd0, flag_zero}, {31'd0, exp_z});
            check("flag_carry", {31'd0, flag_carry}, {31'd0, exp_c});
            check("we_one_cycle", {31'd0, write_enable}, 32'd0);
            flag_pend = 1'b0;
        end
        if (write_enable) begin
            if (sb.size() == 0) begin
                check("spurious_write", 32'd1, 32'd0);
            end else begin
                e = sb.pop_front();
                check("address_w", {28'd0, address_w}, {28'd0, e.addr});
                check("data_in_w", {16'd0, data_in_w}, {16'd0, e.data});
                check("done_with_we", {31'd0, done}, 32'd1);
                check("wb_latency", cyc, e.wb_cyc);
                exp_z     = e.zero;
                exp_c     = e.carry;
                flag_pend = 1'b1;
            end
        end
    end

    task automatic set_reg(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] v);
        @(negedge clk);
        load_en   = 1'b1;
        load_addr = a;
        load_data = v;
        @(negedge clk);
        load_en   = 1'b0;
    endtask

    task automatic issue_op(input logic [2:0] op, input logic [ADDR_W-1:0] s1,
                            input logic [ADDR_W-1:0] s2, input logic [ADDR_W-1:0] d);
        int g = 0;
        @(negedge clk);
        while (busy && g < 50) begin
            @(negedge clk);
            g++;
        end
        if (busy) check("idle_timeout", 32'd1, 32'd0);
        sb.push_back(model(op, regs[s1], regs[s2], d, cyc + ((op == 3'd6) ? 19 : 3)));
        opcode = op;
        rs1    = s1;
        rs2    = s2;
        rd     = d;
        start  = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic wait_done();
        int g = 0;
        do begin
            @(negedge clk);
            g++;
        end while (!done && g < 40);
        if (!done) check("done_timeout", 32'd1, 32'd0);
    endtask

    task automatic run_op(input logic [2:0] op, input logic [ADDR_W-1:0] s1,
                          input logic [ADDR_W-1:0] s2, input logic [ADDR_W-1:0] d);
        issue_op(op, s1, s2, d);
        wait_done();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        reset = 1'b0; start = 1'b0; opcode = '0; rs1 = '0; rs2 = '0; rd = '0;
        load_en = 1'b0; load_addr = '0; load_data = '0;
        repeat (3) @(negedge clk);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_we", {31'd0, write_enable}, 32'd0);
        check("rst_flags", {30'd0, flag_zero, flag_carry}, 32'd0);
        check("rst_addr_ab", {24'd0, address_a, address_b}, 32'd0);
        check("rst_write_port", {12'd0, address_w, data_in_w}, 32'd0);
        reset = 1'b1;

        set_reg(1, 16'd5);      set_reg(2, 16'd7);
        run_op(3'd0, 1, 2, 3);                      // ADD 5+7
        set_reg(1, 16'h0003);   set_reg(2, 16'h0005);
        run_op(3'd1, 1, 2, 4);                      // SUB borrow
        set_reg(1, 16'h1234);   set_reg(2, 16'h1234);
        run_op(3'd1, 1, 2, 5);                      // SUB to zero
        set_reg(1, 16'hFFFF);   set_reg(2, 16'h0001);
        run_op(3'd0, 1, 2, 6);                      // ADD wrap with carry
        set_reg(3, 16'hF0F0);   set_reg(4, 16'h3C3C);
        run_op(3'd2, 3, 4, 7);
        run_op(3'd3, 3, 4, 8);
        run_op(3'd4, 3, 4, 9);
        run_op(3'd5, 4, 3, 10);                     // SLT true
        run_op(3'd5, 3, 4, 11);                     // SLT false
        run_op(3'd7, 3, 0, 12);                     // MOV

        // MUL 300*300 with busy monitoring and an ignored start mid-operation
        set_reg(1, 16'd300);    set_reg(2, 16'd300);
        issue_op(3'd6, 1, 2, 13);
        for (int i = 0; i < 17; i++) begin
            @(negedge clk);
            check("mul_busy", {31'd0, busy}, 32'd1);
            if (i == 6) begin
                opcode = 3'd0; rs1 = 1; rs2 = 2; rd = 14; start = 1'b1;
            end else begin
                start = 1'b0;
            end
        end
        wait_done();

        // Destination equals source, then an immediate dependent op
        set_reg(1, 16'd1);      set_reg(2, 16'd4);
        run_op(3'd0, 2, 1, 2);
        run_op(3'd0, 2, 2, 5);
        @(negedge clk);
        check("raw_r2", {16'd0, regs[2]}, 32'd5);
        check("raw_r5", {16'd0, regs[5]}, 32'd10);

        // Reset during MUL aborts the write
        set_reg(15, 16'hBEEF);
        set_reg(1, 16'd3);      set_reg(2, 16'd3);
        issue_op(3'd6, 1, 2, 15);
        repeat (6) @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_we", {31'd0, write_enable}, 32'd0);
        sb.delete();
        @(negedge clk);
        start = 1'b1; opcode = 3'd0; rs1 = 1; rs2 = 2; rd = 14;
        @(posedge clk);
        #1;
        check("start_in_reset", {31'd0, busy}, 32'd0);
        start = 1'b0;
        @(negedge clk);
        check("abort_addr_ab", {24'd0, address_a, address_b}, 32'd0);
        reset = 1'b1;
        repeat (25) @(negedge clk);
        check("abort_no_write", {16'd0, regs[15]}, 32'h0000BEEF);

        run_op(3'd0, 1, 2, 6);                      // recovery after abort
        repeat (3) @(negedge clk);
        check("sb_empty", sb.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
